// File: rtl/pov_col_scanner_pkg.sv
// Shared constants and FSM encoding for the POV column scanner.
package pov_col_scanner_pkg;

    localparam int unsigned NcolDefault     = 128;
    localparam int unsigned Log2NcolDefault = 7;
    localparam int unsigned LedW            = 16;
    localparam int unsigned DirW            = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCapt,
        StShift,
        StLatch
    } state_e;

endpackage

// File: rtl/pov_col_scanner_period_meter.sv
// Hall index synchroniser, rotation period measurement and column slot timer.
module pov_col_scanner_period_meter #(
    parameter int unsigned NCOL      = 128,
    parameter int unsigned LOG2_NCOL = 7,
    parameter int unsigned PER_W     = 24
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 hall_i,
    output logic                 tick_o,
    output logic [LOG2_NCOL-1:0] col_o,
    output logic                 valid_o
);

    localparam logic [PER_W-1:0]     PerMax  = '1;
    localparam logic [LOG2_NCOL-1:0] ColLast = LOG2_NCOL'(NCOL - 1);

    logic [2:0]           hall_sync_q;
    logic [PER_W-1:0]     per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]     per_last_q, per_last_d;
    logic [PER_W-1:0]     timer_q, timer_d;
    logic [PER_W-1:0]     col_period;
    logic [LOG2_NCOL-1:0] col_q, col_d;
    logic                 seen_q, seen_d;
    logic                 valid_q, valid_d;
    logic                 tick_q, tick_d;
    logic                 idx;
    logic                 terminal;

    assign idx = hall_sync_q[1] & ~hall_sync_q[2];

    always_comb begin
        col_period = per_last_q >> LOG2_NCOL;
        if (col_period == '0) begin
            col_period = PER_W'(1);
        end
    end

    // Ticks stop at the last column; only a new index restarts the revolution.
    assign terminal = valid_q && (col_q != ColLast) && (timer_q == col_period - PER_W'(1));

    always_comb begin
        per_cnt_d  = per_cnt_q;
        per_last_d = per_last_q;
        timer_d    = timer_q;
        col_d      = col_q;
        seen_d     = seen_q;
        valid_d    = valid_q;
        tick_d     = 1'b0;
        if (idx) begin
            per_last_d = per_cnt_q;
            per_cnt_d  = '0;
            seen_d     = 1'b1;
            if (seen_q) begin
                valid_d = 1'b1;
                col_d   = '0;
                timer_d = '0;
                tick_d  = 1'b1;
            end
        end else begin
            if (per_cnt_q == PerMax) begin
                valid_d = 1'b0;
                seen_d  = 1'b0;
            end else begin
                per_cnt_d = per_cnt_q + PER_W'(1);
            end
            if (terminal) begin
                timer_d = '0;
                col_d   = col_q + LOG2_NCOL'(1);
                tick_d  = 1'b1;
            end else if (valid_q && (col_q != ColLast)) begin
                timer_d = timer_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hall_sync_q <= '0;
            per_cnt_q   <= '0;
            per_last_q  <= '0;
            timer_q     <= '0;
            col_q       <= '0;
            seen_q      <= 1'b0;
            valid_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            hall_sync_q <= {hall_sync_q[1:0], hall_i};
            per_cnt_q   <= per_cnt_d;
            per_last_q  <= per_last_d;
            timer_q     <= timer_d;
            col_q       <= col_d;
            seen_q      <= seen_d;
            valid_q     <= valid_d;
            tick_q      <= tick_d;
        end
    end

    assign tick_o  = tick_q;
    assign col_o   = col_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pov_col_scanner.sv
// POV column RAM reader: per-slot RAM fetch, serial shift into the LED chain and latch.
// Build option POV_DIR_REVERSE_EN mirrors the read address (dir = NCOL-1-col).
module pov_col_scanner
    import pov_col_scanner_pkg::*;
#(
    parameter int unsigned NCOL      = NcolDefault,
    parameter int unsigned LOG2_NCOL = Log2NcolDefault,
    parameter int unsigned PER_W     = 24,
    parameter int unsigned SCLK_DIV  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hall,
    output logic [DirW-1:0] dir,
    input  logic [LedW-1:0] datoram,
    output logic            sclk,
    output logic            sdata,
    output logic            latch,
    output logic            valid,
    output logic            overrun,
    output logic            busy
);

    localparam int unsigned CntW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BitW = $clog2(LedW);
    localparam logic [CntW-1:0]      CntLast = CntW'(SCLK_DIV - 1);
    localparam logic [LOG2_NCOL-1:0] ColLast = LOG2_NCOL'(NCOL - 1);

    logic                 tick;
    logic [LOG2_NCOL-1:0] col;
    logic [DirW-1:0]      col_addr;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic [LedW-1:0] shreg_q, shreg_d;
    logic [DirW-1:0] dir_q, dir_d;
    logic            phase_q, phase_d;
    logic            blank_q, blank_d;
    logic            blank_pend_q, blank_pend_d;
    logic            pending_q, pending_d;
    logic            valid_prev_q;
    logic            sclk_q, sclk_d;
    logic            sdata_q, sdata_d;
    logic            latch_q, latch_d;
    logic            overrun_q, overrun_d;
    logic            busy_q, busy_d;
    logic            valid_fall;
    logic            take_pending;
    logic            take_tick;

    pov_col_scanner_period_meter #(
        .NCOL      (NCOL),
        .LOG2_NCOL (LOG2_NCOL),
        .PER_W     (PER_W)
    ) u_period_meter (
        .clk_i   (clk),
        .reset_i (reset),
        .hall_i  (hall),
        .tick_o  (tick),
        .col_o   (col),
        .valid_o (valid)
    );

`ifdef POV_DIR_REVERSE_EN
    assign col_addr = DirW'(ColLast - col);
`else
    assign col_addr = DirW'(col);
`endif

    assign valid_fall = valid_prev_q & ~valid;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        dir_d        = dir_q;
        phase_d      = phase_q;
        blank_d      = blank_q;
        blank_pend_d = blank_pend_q;
        pending_d    = pending_q;
        sclk_d       = sclk_q;
        sdata_d      = sdata_q;
        latch_d      = latch_q;
        busy_d       = busy_q;
        overrun_d    = 1'b0;
        take_pending = 1'b0;
        take_tick    = 1'b0;

        case (state_q)
            StIdle: begin
                if (blank_pend_q) begin
                    // Stall blanking: no RAM read, dir keeps its last value.
                    blank_pend_d = 1'b0;
                    blank_d      = 1'b1;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = StAddr;
                end else if (valid && (pending_q || tick)) begin
                    take_pending = pending_q;
                    take_tick    = ~pending_q;
                    if (pending_q) begin
                        pending_d = 1'b0;
                    end
                    blank_d = 1'b0;
                    dir_d   = col_addr;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (cnt_q == CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StCapt;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCapt: begin
                shreg_d = blank_q ? '0 : datoram;
                sdata_d = blank_q ? 1'b0 : datoram[LedW-1];
                sclk_d  = 1'b0;
                phase_d = 1'b0;
                bit_d   = '0;
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        if (bit_q == BitW'(LedW - 1)) begin
                            sdata_d = 1'b0;
                            latch_d = 1'b1;
                            state_d = StLatch;
                        end else begin
                            bit_d   = bit_q + BitW'(1);
                            shreg_d = shreg_q << 1;
                            sdata_d = shreg_q[LedW-2];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLatch: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    latch_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // One-deep request buffer; a tick finding it occupied is dropped.
        if (valid_fall) begin
            pending_d    = 1'b0;
            blank_pend_d = 1'b1;
        end else if (tick && !take_tick) begin
            if (pending_q && !take_pending) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            dir_q        <= '0;
            phase_q      <= 1'b0;
            blank_q      <= 1'b0;
            blank_pend_q <= 1'b0;
            pending_q    <= 1'b0;
            valid_prev_q <= 1'b0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            latch_q      <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            dir_q        <= dir_d;
            phase_q      <= phase_d;
            blank_q      <= blank_d;
            blank_pend_q <= blank_pend_d;
            pending_q    <= pending_d;
            valid_prev_q <= valid;
            sclk_q       <= sclk_d;
            sdata_q      <= sdata_d;
            latch_q      <= latch_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign dir     = dir_q;
    assign sclk    = sclk_q;
    assign sdata   = sdata_q;
    assign latch   = latch_q;
    assign overrun = overrun_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_pov_col_scanner.sv
// Scoreboard bench for pov_col_scanner at reduced size (8 columns, 12-bit period, SCLK_DIV=2).
module tb_pov_col_scanner;

    localparam int unsigned NCOL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hall = 1'b0;
    logic [7:0]  dir;
    logic [15:0] datoram = '0;
    logic        sclk, sdata, latch, valid, overrun, busy;

    typedef struct packed {
        logic        chk_dir;
        logic [7:0]  dir;
        logic [15:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   nbits = 0;
    int   latches = 0;
    int   sclk_rises = 0;
    int   ovr_cnt = 0;
    logic [15:0] sh_word = '0;
    logic sclk_p = 1'b0;
    logic latch_p = 1'b0;

    pov_col_scanner #(
        .NCOL      (NCOL),
        .LOG2_NCOL (3),
        .PER_W     (12),
        .SCLK_DIV  (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .hall    (hall),
        .dir     (dir),
        .datoram (datoram),
        .sclk    (sclk),
        .sdata   (sdata),
        .latch   (latch),
        .valid   (valid),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Column RAM: one cycle read latency, contents tagged with the address.
    always @(posedge clk) datoram <= {8'hA5, dir};

    function automatic logic [7:0] exp_dir(input int c);
`ifdef POV_DIR_REVERSE_EN
        return 8'(NCOL - 1 - c);
`else
        return 8'(c);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_col(input int c);
        exp_t e;
        e.chk_dir = 1'b1;
        e.dir     = exp_dir(c);
        e.word    = {8'hA5, exp_dir(c)};
        exp_q.push_back(e);
    endtask

    // Rising edges of hall are exactly 'period' cycles apart.
    task automatic hall_pulse(input int period);
        hall = 1'b1;
        repeat (4) @(negedge clk);
        hall = 1'b0;
        repeat (period - 4) @(negedge clk);
    endtask

    task automatic wait_latches(input int target, input int budget, input string name);
        int n = 0;
        while (latches < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (latches >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Monitor: rebuilds the shifted word and checks it at each latch strobe.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            nbits = 0;
        end else begin
            if (sclk && !sclk_p) begin
                sh_word = {sh_word[14:0], sdata};
                nbits++;
                sclk_rises++;
            end
            if (latch && !latch_p) begin
                latches++;
                check("bits_per_word", nbits, 16);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (e.chk_dir) check("sb_dir", dir, e.dir);
                    check("sb_word", sh_word, e.word);
                end else begin
                    check("word_vs_dir", sh_word, {8'hA5, dir});
                end
                nbits = 0;
            end
            if (overrun) ovr_cnt++;
        end
        sclk_p  = sclk;
        latch_p = latch;
    end

    initial begin
        int base_lat, base_ovr, base_sclk, n;
        exp_t blank;

        // Power-on reset
        repeat (2) @(negedge clk);
        check("reset_outputs", {dir, sclk, sdata, latch, valid, overrun, busy}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {dir, sclk, sdata, latch, valid, overrun, busy}, 0);

        // Normal rotation: period 801 -> col_period 100
        base_lat = latches;
        base_ovr = ovr_cnt;
        hall_pulse(801);
        for (int c = 0; c < 8; c++) push_col(c);
        hall_pulse(801);
        for (int c = 0; c < 3; c++) push_col(c);
        hall_pulse(4);
        wait_latches(base_lat + 11, 3000, "t2_latch_wait");
        check("t2_no_overrun", ovr_cnt - base_ovr, 0);
        check("t2_queue_drained", exp_q.size(), 0);

        // Reset for 5 clk in the middle of col 3's shift
        n = 0;
        while (!(busy && nbits >= 3) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t1_mid_shift_reached", (busy && nbits >= 3) ? 32'd1 : 32'd0, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t1_reset_outputs", {dir, sclk, sdata, latch, valid, overrun, busy}, 0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        base_lat = latches;
        repeat (2000) @(negedge clk);
        check("t1_no_latch_after_reset", latches - base_lat, 0);
        check("t1_idle_after_reset", {sclk, latch, valid, busy}, 0);

        // Fast rotation: period 401 -> col_period 50 < sequence length
        base_lat = latches;
        base_ovr = ovr_cnt;
        repeat (3) hall_pulse(401);
        hall_pulse(4);
        repeat (1000) @(negedge clk);
        check("t3_overrun_seen", (ovr_cnt > base_ovr) ? 32'd1 : 32'd0, 32'd1);
        check("t3_words_latched", (latches - base_lat > 8) ? 32'd1 : 32'd0, 32'd1);
        check("t3_fsm_idle", busy, 0);
        check("t3_still_valid", valid, 1);

        // Stall: valid falls, one blank word, then silence
        blank.chk_dir = 1'b0;
        blank.dir     = '0;
        blank.word    = 16'h0000;
        exp_q.push_back(blank);
        base_lat = latches;
        n = 0;
        while (valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("t4_valid_fall", valid, 0);
        wait_latches(base_lat + 1, 300, "t4_blank_latch");
        repeat (10) @(negedge clk);
        base_lat  = latches;
        base_sclk = sclk_rises;
        repeat (1500) @(negedge clk);
        check("t4_quiet_latch", latches - base_lat, 0);
        check("t4_quiet_sclk", sclk_rises - base_sclk, 0);

        // Index arriving mid-shift of col 5
        hall_pulse(801);
        for (int c = 0; c < 6; c++) push_col(c);
        push_col(0);
        base_lat = latches;
        hall_pulse(4);
        wait_latches(base_lat + 5, 1000, "t5_first_cols");
        n = 0;
        while (!(busy && dir == exp_dir(5) && nbits >= 8) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t5_mid_shift_reached", (busy && dir == exp_dir(5)) ? 32'd1 : 32'd0, 32'd1);
        hall_pulse(4);
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_latch_exit", busy, 0);
        @(negedge clk);
        check("t5_next_dir", dir, exp_dir(0));
        check("t5_next_busy", busy, 1);
        repeat (700) @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
